// File: rtl/filtro_secuenciador.sv
// Micro-step sequencer for the band-pass filter datapath: on each accepted sample
// strobe it shifts the F history, runs four multiply-accumulate steps and flags y(k).
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for run && sample_tick
// SHIFT   | F(k-1) <= F(k), F(k-2) <= F(k-1)
// CALC_A1 | A1 = U + c0*F1
// CALC_FK | F  = A1 + c1*F2
// CALC_A2 | A2 = F + c2*F1
// CALC_Y  | Y  = A2 + c3*F2
// DONE    | yk_valid pulse, back to IDLE
module filtro_secuenciador #(
  parameter int         ARIT_LAT = 1,
  parameter logic [2:0] S_FK     = 3'd0,
  parameter logic [2:0] S_FK1    = 3'd1,
  parameter logic [2:0] S_FK2    = 3'd2,
  parameter logic [2:0] Z_FK     = 3'd0,
  parameter logic [2:0] Z_UK     = 3'd1,
  parameter logic [2:0] Z_A1     = 3'd2,
  parameter logic [2:0] Z_A2     = 3'd3,
  parameter logic [1:0] C0       = 2'd0,
  parameter logic [1:0] C1       = 2'd1,
  parameter logic [1:0] C2       = 2'd2,
  parameter logic [1:0] C3       = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       sample_tick,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  output logic       en4,
  output logic       en5,
  output logic       en6,
  output logic       en7,
  output logic [2:0] selmuxS,
  output logic [2:0] selmuxZ,
  output logic [1:0] selmuxC,
  output logic       busy,
  output logic       yk_valid,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE, SHIFT, CALC_A1, CALC_FK, CALC_A2, CALC_Y, DONE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(ARIT_LAT - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [6:0] en_q;   // bit n-1 drives en<n>
  logic [7:0] sel_q;  // {S, Z, C}

  function automatic logic [6:0] step_en(state_t s);
    case (s)
      CALC_A1: step_en = 7'b0010000;
      CALC_FK: step_en = 7'b0000010;
      CALC_A2: step_en = 7'b0100000;
      CALC_Y:  step_en = 7'b0000001;
      default: step_en = 7'b0000000;
    endcase
  endfunction

  function automatic logic [7:0] step_sel(state_t s);
    case (s)
      CALC_A1: step_sel = {S_FK1, Z_UK, C0};
      CALC_FK: step_sel = {S_FK2, Z_A1, C1};
      CALC_A2: step_sel = {S_FK1, Z_FK, C2};
      CALC_Y:  step_sel = {S_FK2, Z_A2, C3};
      default: step_sel = 8'd0;
    endcase
  endfunction

  function automatic state_t step_next(state_t s);
    case (s)
      CALC_A1: step_next = CALC_FK;
      CALC_FK: step_next = CALC_A2;
      CALC_A2: step_next = CALC_Y;
      default: step_next = DONE;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      en_q     <= 7'd0;
      sel_q    <= 8'd0;
      busy     <= 1'b0;
      yk_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      en_q     <= 7'd0;
      yk_valid <= 1'b0;
      if (sample_tick && busy) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (run && sample_tick) begin
            state <= SHIFT;
            en_q  <= 7'b0001100;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          state    <= CALC_A1;
          wait_cnt <= LAT_M1;
          sel_q    <= step_sel(CALC_A1);
          if (LAT_M1 == 4'd0) en_q <= step_en(CALC_A1);
        end
        CALC_A1, CALC_FK, CALC_A2, CALC_Y: begin
          // Selects hold for the whole step; the enable fires only as the count hits zero.
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1) en_q <= step_en(state);
          end else if (state == CALC_Y) begin
            state    <= DONE;
            sel_q    <= 8'd0;
            yk_valid <= 1'b1;
          end else begin
            state    <= step_next(state);
            wait_cnt <= LAT_M1;
            sel_q    <= step_sel(step_next(state));
            if (LAT_M1 == 4'd0) en_q <= step_en(step_next(state));
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          sel_q <= 8'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign {en7, en6, en5, en4, en3, en2, en1} = en_q;
  assign {selmuxS, selmuxZ, selmuxC}         = sel_q;

endmodule
